// File: rtl/usart_rx.sv
// usart_rx: oversampled serial receiver (start, DATA_W data LSB-first, optional even parity, stop)
// with a one-entry holding register. Define USART_RX_MAJVOTE_EN for 3-sample majority bit decisions.
module usart_rx #(
   parameter int unsigned OVS    = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_usrt,
   input  logic              par_en,
   input  logic              rxd,
   input  logic              rd,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              par_err,
   output logic              frm_err,
   output logic              ovr_err,
   output logic              busy,
   output logic              rts
);

   localparam int unsigned TW = $clog2(OVS);
   localparam int unsigned BW = $clog2(DATA_W);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
`ifdef USART_RX_MAJVOTE_EN
   localparam logic [TW-1:0] T_SMP = TW'(OVS / 2 + 1);
`else
   localparam logic [TW-1:0] T_SMP = TW'(OVS / 2);
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t            state;
   logic [TW-1:0]     tick;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              par_lat;
   logic              par_pend;
   logic              sync1, rxs;
   logic              bit_v;
   logic              smp, last, frame_done;

   // Two-flop synchroniser for the asynchronous line, idle high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

`ifdef USART_RX_MAJVOTE_EN
   logic [1:0] vote_q;

   // Last two tick samples; with the current one they form the vote window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         vote_q <= 2'b11;
      else if (en_usrt) vote_q <= {vote_q[0], rxs};
   end

   assign bit_v = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
`else
   assign bit_v = rxs;
`endif

   assign smp        = en_usrt && (tick == T_SMP);
   assign last       = en_usrt && (tick == T_LAST);
   assign frame_done = smp && (state == S_STOP);

   // Frame sequencer; every decision waits for an oversample tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         tick     <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_lat  <= 1'b0;
         par_pend <= 1'b0;
         busy     <= 1'b0;
      end else if (en_usrt) begin
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state   <= S_START;
                  tick    <= TW'(1);
                  par_lat <= par_en;
                  busy    <= 1'b1;
               end
            end
            S_START: begin
               tick <= tick + TW'(1);
               if (smp && bit_v) begin
                  state <= S_IDLE;
                  tick  <= '0;
                  busy  <= 1'b0;
               end else if (last) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
               end
            end
            S_DATA: begin
               tick <= tick + TW'(1);
               if (smp) shreg <= {bit_v, shreg[DATA_W-1:1]};
               if (last) begin
                  if (bit_idx == BW'(DATA_W - 1)) state <= par_lat ? S_PARITY : S_STOP;
                  else                            bit_idx <= bit_idx + BW'(1);
               end
            end
            S_PARITY: begin
               tick <= tick + TW'(1);
               if (smp)  par_pend <= bit_v ^ (^shreg);
               if (last) state <= S_STOP;
            end
            S_STOP: begin
               tick <= tick + TW'(1);
               // Leave at mid-stop so an immediately following start edge is caught.
               if (smp) begin
                  state <= S_IDLE;
                  tick  <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               tick  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: a completing frame loads unless an unread byte blocks it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data    <= '0;
         valid   <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
         rts     <= 1'b1;
      end else begin
         if (rd && valid) begin
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
            rts     <= 1'b1;
         end
         if (frame_done) begin
            if (!valid || rd) begin
               data    <= shreg;
               par_err <= par_lat & par_pend;
               frm_err <= ~bit_v;
               valid   <= 1'b1;
               rts     <= 1'b0;
            end else begin
               ovr_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: frame-level model of the holding register checked every cycle,
// plus directed literal checks for each scenario.
module tb_usart_rx;

`ifdef USART_RX_MAJVOTE_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   logic       clk = 1'b0;
   logic       rst, en_usrt, par_en, rxd, rd;
   logic [7:0] data;
   logic       valid, par_err, frm_err, ovr_err, busy, rts;

   usart_rx #(.OVS(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .en_usrt(en_usrt), .par_en(par_en), .rxd(rxd), .rd(rd),
      .data(data), .valid(valid), .par_err(par_err), .frm_err(frm_err),
      .ovr_err(ovr_err), .busy(busy), .rts(rts)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } frame_t;

   frame_t     pend[$];
   int         cyc = 0;
   logic       rd_q = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_pe    = 1'b0;
   logic       m_fe    = 1'b0;
   logic       m_ovr   = 1'b0;

   always @(posedge clk) begin
      cyc++;
      rd_q = rd;
   end

   // Model of the host-visible register, applied for the edge just passed, then compared.
   always @(negedge clk) begin
      logic   old_valid;
      frame_t e;
      if (!rst) begin
         m_data = 8'h00; m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
         pend.delete();
      end else begin
         old_valid = m_valid;
         if (rd_q && m_valid) begin
            m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
         end
         if (pend.size() > 0 && pend[0].cyc == cyc) begin
            e = pend.pop_front();
            if (!old_valid || rd_q) begin
               m_data = e.d; m_pe = e.pe; m_fe = e.fe; m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
      total++;
      if ({valid, data, par_err, frm_err, ovr_err, rts} !==
          {m_valid, m_data, m_pe, m_fe, m_ovr, ~m_valid}) begin
         bad++;
         $display("FAIL model cyc=%0d: got v=%b d=%h pe=%b fe=%b ovr=%b rts=%b, need v=%b d=%h pe=%b fe=%b ovr=%b rts=%b",
                  cyc, valid, data, par_err, frm_err, ovr_err, rts,
                  m_valid, m_data, m_pe, m_fe, m_ovr, ~m_valid);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one frame from a negedge; spike_bit >= 0 puts a 1-clk high pulse mid-bit.
   task automatic send_frame(input logic [7:0] d, input bit use_par, input bit pbit,
                             input bit stop, input int spike_bit);
      logic [10:0] bits;
      int          s;
      frame_t      e;
      s = use_par ? 10 : 9;
      bits = '0;
      bits[8:1] = d;
      if (use_par) begin
         bits[9]  = pbit;
         bits[10] = stop;
      end else begin
         bits[9] = stop;
      end
      par_en = use_par;
      e.cyc = cyc + 7 + 8 * s + MAJ;
      e.d   = d;
      e.pe  = use_par && (pbit != ^d);
      e.fe  = ~stop;
      pend.push_back(e);
      for (int b = 0; b <= s; b++) begin
         rxd = bits[b];
         if (b == spike_bit) begin
            wait_clks(4);
            rxd = 1'b1;
            wait_clks(1);
            rxd = bits[b];
            wait_clks(3);
         end else begin
            wait_clks(8);
         end
      end
      rxd = 1'b1;
   endtask

   task automatic pulse_rd;
      rd = 1'b1;
      wait_clks(1);
      rd = 1'b0;
   endtask

   initial begin
      int c;
      rst = 1'b0; en_usrt = 1'b1; par_en = 1'b0; rxd = 1'b1; rd = 1'b0;
      #12;
      chk("reset valid", 8'(valid), 8'h00);
      chk("reset rts",   8'(rts),   8'h01);
      chk("reset busy",  8'(busy),  8'h00);
      @(negedge clk); #2 rst = 1'b1;
      wait_clks(4);

      // Basic frame, then host read.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      wait_clks(4);
      chk("t1 data",  data,          8'hA5);
      chk("t1 valid", 8'(valid),     8'h01);
      chk("t1 rts",   8'(rts),       8'h00);
      chk("t1 errs",  8'({par_err, frm_err, ovr_err}), 8'h00);
      pulse_rd();
      chk("t1 rd valid", 8'(valid), 8'h00);
      chk("t1 rd rts",   8'(rts),   8'h01);

      // Parity: 0x3C has even ones, so parity bit 1 is wrong and 0 is right.
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
      wait_clks(4);
      chk("t2 bad data", data,        8'h3C);
      chk("t2 bad pe",   8'(par_err), 8'h01);
      pulse_rd();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
      wait_clks(4);
      chk("t2 good pe", 8'(par_err), 8'h00);
      chk("t2 good v",  8'(valid),   8'h01);
      pulse_rd();
      par_en = 1'b0;

      // Short low glitch is a false start.
      wait_clks(4);
      c = cyc;
      rxd = 1'b0;
      wait_clks(2);
      rxd = 1'b1;
      wait_clks(c + 4 - cyc);
      chk("t3 busy mid", 8'(busy), 8'h01);
      wait_clks(c + 8 - cyc);
      chk("t3 busy end", 8'(busy),  8'h00);
      chk("t3 valid",    8'(valid), 8'h00);
      wait_clks(8);

      // Back-to-back frames without a read: second is dropped.
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
      wait_clks(4);
      chk("t4 data", data,        8'h11);
      chk("t4 ovr",  8'(ovr_err), 8'h01);
      pulse_rd();
      chk("t4 clr", 8'({valid, par_err, frm_err, ovr_err}), 8'h00);

      // Stop bit low: framing error; the trailing low re-arms only a false start.
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
      wait_clks(16);
      chk("t5 fe",    8'(frm_err), 8'h01);
      chk("t5 data",  data,        8'h55);
      chk("t5 valid", 8'(valid),   8'h01);

      // Reset during data bit 3, with a byte still held.
      rxd = 1'b0; wait_clks(8);
      rxd = 1'b1; wait_clks(8);
      rxd = 1'b0; wait_clks(8);
      rxd = 1'b1; wait_clks(8);
      rxd = 1'b0; wait_clks(4);
      #2 rst = 1'b0;
      #1;
      chk("t6 rst valid", 8'(valid), 8'h00);
      chk("t6 rst data",  data,      8'h00);
      chk("t6 rst rts",   8'(rts),   8'h01);
      chk("t6 rst busy",  8'(busy),  8'h00);
      chk("t6 rst errs",  8'({par_err, frm_err, ovr_err}), 8'h00);
      rxd = 1'b1;
      wait_clks(2);
      #2 rst = 1'b1;
      wait_clks(10);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
      wait_clks(4);
      chk("t6 data",  data,      8'h81);
      chk("t6 valid", 8'(valid), 8'h01);
      pulse_rd();

`ifdef USART_RX_MAJVOTE_EN
      // One-clock spike at mid-bit is outvoted.
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 3);
      wait_clks(4);
      chk("t7 spike data",  data,      8'h00);
      chk("t7 spike valid", 8'(valid), 8'h01);
      pulse_rd();
`endif

      wait_clks(4);
      chk("pending frames", 8'(pend.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
